avalon_ram_slave: RTL and testbench

Avalon-MM slave memory that sits directly downstream of the CPU's bus controller and services its single shared instruction/data port. It holds a word-organised RAM and answers reads and byte-enabled writes. Each transfer inserts a programmable number of wait states via `av_waitrequest`, so the controller's stall paths are exercised. It is the memory model used in CPU testbenches and the on-chip RAM in synthesised builds.

---
 rtl/avalon_ram_pkg.sv | 15 +
 rtl/avalon_ram_lfsr.sv | 33 +++
 rtl/avalon_ram_slave.sv | 155 +++++++++++++++
 tb/tb_avalon_ram_slave.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/avalon_ram_pkg.sv
// Shared types and constants for the Avalon-MM RAM slave.
// Optional build macro used by the slave: AVALON_RAM_RANDOM_WAIT_EN.
package avalon_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } ram_state_t;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC0_0000;
    localparam int unsigned WAIT_CNT_W        = 5;

endpackage

// File: rtl/avalon_ram_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) stepping once per advance pulse.
// Only instantiated when AVALON_RAM_RANDOM_WAIT_EN is defined.
module avalon_ram_lfsr
    import avalon_ram_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
        end
    end

    // An all-zero state would lock up, so a zero seed is replaced by 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/avalon_ram_slave.sv
// Avalon-MM word RAM slave with byte-enabled writes and programmable wait states.
// Define AVALON_RAM_RANDOM_WAIT_EN to add 0..3 LFSR-driven extra wait cycles per transfer.
module avalon_ram_slave
  import avalon_ram_pkg::*;
#(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = "",
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  input  logic [3:0]  av_byteenable,
  output logic        av_waitrequest,
  output logic [31:0] av_readdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  ram_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  is_wr_q, is_wr_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  req, accept, commit;
  logic [31:0]           addr_sel, offset, rd_word;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic [1:0]            unused_offset_lsb;
  logic [WAIT_CNT_W-1:0] wait_total;

  assign req    = av_read | av_write;
  assign accept = (state_q == IDLE) && req;

  // One decoder serves both paths: live address when accepting, latched address afterwards.
  assign addr_sel          = (state_q == IDLE) ? av_address : addr_q;
  assign offset            = addr_sel - BASE_ADDR;
  assign in_range          = offset[31:2] < 30'(DEPTH);
  assign idx               = offset[IDX_W+1:2];
  assign rd_word           = in_range ? mem[idx] : 32'h0;
  assign unused_offset_lsb = offset[1:0];

`ifdef AVALON_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_val;
  logic [13:0] unused_lfsr_hi;

  avalon_ram_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (accept),
    .seed    (LFSR_SEED),
    .value   (lfsr_val)
  );

  assign unused_lfsr_hi = lfsr_val[15:2];
  assign wait_total     = WAIT_CNT_W'(WAIT_CYCLES) + WAIT_CNT_W'(lfsr_val[1:0]);
`else
  logic [15:0] unused_seed;

  assign unused_seed = LFSR_SEED;
  assign wait_total  = WAIT_CNT_W'(WAIT_CYCLES);
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    is_wr_d        = is_wr_q;
    rdata_d        = rdata_q;
    av_waitrequest = 1'b0;
    commit         = 1'b0;

    unique case (state_q)
      IDLE: begin
        av_waitrequest = req;
        if (req) begin
          addr_d  = av_address;
          wdata_d = av_writedata;
          be_d    = av_byteenable;
          is_wr_d = av_write;
          cnt_d   = wait_total;
          if (wait_total != '0) begin
            state_d = WAIT;
          end else begin
            state_d = ACK;
            if (!av_write) rdata_d = rd_word;
          end
        end
      end
      WAIT: begin
        av_waitrequest = 1'b1;
        cnt_d          = cnt_q - 1'b1;
        if (is_wr_q ? !av_write : !av_read) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = ACK;
          if (!is_wr_q) rdata_d = rd_word;
        end
      end
      ACK: begin
        commit  = is_wr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset; all words start at zero.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (commit && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign av_readdata = rdata_q;

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Directed bench for avalon_ram_slave: one instance with 0 and one with 3 wait states.
module tb_avalon_ram_slave;

    localparam logic [31:0] BASE  = 32'hBFC0_0000;
    localparam int unsigned DEPTH = 64;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [3:0]  ben  [2];
    logic        rd   [2];
    logic        wr   [2];
    logic        wreq0, wreq1;
    logic [31:0] rdat0, rdat1;

    int errors = 0;
    int checks = 0;
    bit rnd_exact = 1'b0;
    logic [31:0] sb [$];

    avalon_ram_slave #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .INIT_FILE(""), .LFSR_SEED(SEED)
    ) u_w0 (
        .clk(clk), .reset_n(reset_n), .av_address(addr[0]), .av_read(rd[0]), .av_write(wr[0]),
        .av_writedata(wdat[0]), .av_byteenable(ben[0]), .av_waitrequest(wreq0), .av_readdata(rdat0)
    );

    avalon_ram_slave #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3), .INIT_FILE(""), .LFSR_SEED(SEED)
    ) u_w3 (
        .clk(clk), .reset_n(reset_n), .av_address(addr[1]), .av_read(rd[1]), .av_write(wr[1]),
        .av_writedata(wdat[1]), .av_byteenable(ben[1]), .av_waitrequest(wreq1), .av_readdata(rdat1)
    );

    function automatic logic get_wreq(input int d);
        return (d == 0) ? wreq0 : wreq1;
    endfunction

    function automatic logic [31:0] get_rdat(input int d);
        return (d == 0) ? rdat0 : rdat1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that closes the ACK cycle.
    task automatic xfer(input int d, input bit is_wr, input bit also_rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rexp,
                        input int exp_w, input string tag);
        int w = 0;
        addr[d] = a;
        wdat[d] = wd;
        ben[d]  = be;
        wr[d]   = is_wr;
        rd[d]   = !is_wr || also_rd;
        if (!is_wr) sb.push_back(rexp);
        @(negedge clk);
        while (get_wreq(d) === 1'b1 && w < 40) begin
            w++;
            @(negedge clk);
        end
`ifdef AVALON_RAM_RANDOM_WAIT_EN
        if (rnd_exact) chk({tag, "_wait"}, w, exp_w);
        else chk({tag, "_wait_range"}, {31'b0, (w >= exp_w && w <= exp_w + 3)}, 32'd1);
`else
        chk({tag, "_wait"}, w, exp_w);
`endif
        if (!is_wr) chk({tag, "_data"}, get_rdat(d), sb.pop_front());
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdat[d] = '0; ben[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
        end
        #1 reset_n = 1'b0;
        #12;
        chk("rst_wreq0", {31'b0, wreq0}, 32'd0);
        chk("rst_wreq1", {31'b0, wreq1}, 32'd0);
        chk("rst_rdat0", rdat0, 32'h0);
        chk("rst_rdat1", rdat1, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // zero wait states
        xfer(0, 1, 0, BASE,       32'h2402_0005, 4'hF, '0, 1, "w0_wr0");
        xfer(0, 0, 0, BASE,       '0, 4'h0, 32'h2402_0005, 1, "w0_rd0");
        xfer(0, 1, 0, BASE + 8,   32'h1111_1111, 4'hF, '0, 1, "w0_wr2");
        xfer(0, 1, 0, BASE + 8,   32'hAABB_CCDD, 4'b0100, '0, 1, "w0_be2");
        xfer(0, 0, 0, BASE + 8,   '0, 4'h0, 32'h11BB_1111, 1, "w0_rd2");
        xfer(0, 1, 0, BASE + 8,   32'hFFEE_DDCC, 4'b1001, '0, 1, "w0_be9");
        xfer(0, 0, 0, BASE + 11,  '0, 4'h0, 32'hFFBB_11CC, 1, "w0_rd2lsb");
        xfer(0, 1, 0, BASE + 4*(DEPTH-1), 32'h5A5A_1234, 4'hF, '0, 1, "w0_wrlast");
        xfer(0, 0, 0, BASE + 4*(DEPTH-1), '0, 4'h0, 32'h5A5A_1234, 1, "w0_rdlast");
        xfer(0, 0, 0, BASE + 4*DEPTH, '0, 4'h0, 32'h0, 1, "w0_oor_rd");
        xfer(0, 0, 0, BASE - 4,   '0, 4'h0, 32'h0, 1, "w0_below_rd");
        xfer(0, 1, 0, BASE + 4*DEPTH, 32'hDEAD_BEEF, 4'hF, '0, 1, "w0_oor_wr");
        xfer(0, 0, 0, BASE,       '0, 4'h0, 32'h2402_0005, 1, "w0_alias0");
        xfer(0, 0, 0, BASE + 8,   '0, 4'h0, 32'hFFBB_11CC, 1, "w0_alias2");
        xfer(0, 1, 1, BASE + 12,  32'h0BAD_F00D, 4'hF, '0, 1, "w0_rdwr");
        xfer(0, 0, 0, BASE + 12,  '0, 4'h0, 32'h0BAD_F00D, 1, "w0_rdwr_chk");

        // three wait states
        xfer(1, 1, 0, BASE + 16,  32'hCAFE_BABE, 4'hF, '0, 4, "w3_wr4");
        xfer(1, 0, 0, BASE + 16,  '0, 4'h0, 32'hCAFE_BABE, 4, "w3_rd4");
        xfer(1, 1, 0, BASE + 20,  32'h1234_5678, 4'hF, '0, 4, "w3_wr5");

        // read dropped while waiting
        addr[1] = BASE + 20;
        rd[1]   = 1'b1;
        @(negedge clk);
        chk("ab_rd_req", {31'b0, wreq1}, 32'd1);
        cycles(2);
        rd[1] = 1'b0;
        @(negedge clk);
        chk("ab_rd_wait", {31'b0, wreq1}, 32'd1);
        @(negedge clk);
        chk("ab_rd_idle", {31'b0, wreq1}, 32'd0);
        chk("ab_rd_hold", rdat1, 32'hCAFE_BABE);
        @(posedge clk);
        #1;
        xfer(1, 0, 0, BASE + 20,  '0, 4'h0, 32'h1234_5678, 4, "w3_rd5");

        // write dropped while waiting
        addr[1] = BASE + 16;
        wdat[1] = 32'h0;
        ben[1]  = 4'hF;
        wr[1]   = 1'b1;
        cycles(2);
        wr[1] = 1'b0;
        cycles(3);
        xfer(1, 0, 0, BASE + 16,  '0, 4'h0, 32'hCAFE_BABE, 4, "ab_wr_chk");

        // reset during a pending write
        addr[1] = BASE + 20;
        wdat[1] = 32'hFFFF_0000;
        ben[1]  = 4'hF;
        wr[1]   = 1'b1;
        cycles(2);
        reset_n = 1'b0;
        wr[1]   = 1'b0;
        #1;
        chk("rst_mid_rdat1", rdat1, 32'h0);
        chk("rst_mid_rdat0", rdat0, 32'h0);
        chk("rst_mid_wreq1", {31'b0, wreq1}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 0, 0, BASE + 20,  '0, 4'h0, 32'h1234_5678, 4, "rst_mid_chk");

`ifdef AVALON_RAM_RANDOM_WAIT_EN
        // Two passes from a fresh reset must follow the same LFSR-predicted waits.
        rnd_exact = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            logic [15:0] m;
            m = SEED;
            @(negedge clk) reset_n = 1'b0;
            @(negedge clk) reset_n = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < 100; i++) begin
                xfer(1, 0, 0, BASE + 16, '0, 4'h0, 32'hCAFE_BABE, 4 + int'(m[1:0]), "rnd_rd");
                m = lfsr_step(m);
            end
        end
        rnd_exact = 1'b0;
`endif

        cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
